// File: rtl/shared_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between N_CORES requesters.
// Each granted transaction spends one cycle in ACCESS and one in DONE (ready pulse).
module shared_ram_arbiter #(
  parameter int unsigned N_CORES    = 4,
  parameter int unsigned WIDTH      = 12,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned ID_WIDTH   = $clog2(N_CORES)
) (
  input  logic                          clk,
  input  logic                          rstN,
  input  logic [N_CORES-1:0]            req,
  input  logic [N_CORES-1:0]            wrEnIn,
  input  logic [N_CORES*ADDR_WIDTH-1:0] addrIn,
  input  logic [N_CORES*WIDTH-1:0]      dataIn,
  output logic [N_CORES-1:0]            ready,
  output logic [WIDTH-1:0]              rdData,
  output logic                          grantValid,
  output logic [ID_WIDTH-1:0]           grantId,
  output logic                          ramWrEn,
  output logic [ADDR_WIDTH-1:0]         ramAddr,
  output logic [WIDTH-1:0]              ramDataIn,
  input  logic [WIDTH-1:0]              ramDataOut
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t              r_state;
  logic [ID_WIDTH-1:0] r_ptr;

  logic [N_CORES-1:0]  w_req_m;
  logic [ID_WIDTH-1:0] w_idx;
  logic                w_win_vld;
  logic [ID_WIDTH-1:0] w_win_id;
  logic [ID_WIDTH-1:0] w_ptr_nxt;

  // Rotating priority search from r_ptr; the core completing in DONE is masked out.
  always_comb begin
    w_req_m   = req;
    w_idx     = '0;
    w_win_vld = 1'b0;
    w_win_id  = '0;
    if (r_state == S_DONE) begin
      w_req_m[grantId] = 1'b0;
    end
    for (int unsigned k = 0; k < N_CORES; k++) begin
      w_idx = ID_WIDTH'((32'(r_ptr) + k) % N_CORES);
      if (!w_win_vld && w_req_m[w_idx]) begin
        w_win_vld = 1'b1;
        w_win_id  = w_idx;
      end
    end
    w_ptr_nxt = ID_WIDTH'((32'(w_win_id) + 32'd1) % N_CORES);
  end

  // Read data is valid from the RAM during DONE, passed straight through.
  assign rdData = ramDataOut;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      ready      <= '0;
      grantValid <= 1'b0;
      grantId    <= '0;
      ramWrEn    <= 1'b0;
      ramAddr    <= '0;
      ramDataIn  <= '0;
    end else begin
      ready      <= '0;
      grantValid <= 1'b0;
      ramWrEn    <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_win_vld) begin
            r_state    <= S_ACCESS;
            r_ptr      <= w_ptr_nxt;
            grantId    <= w_win_id;
            grantValid <= 1'b1;
            ramWrEn    <= wrEnIn[w_win_id];
            ramAddr    <= addrIn[32'(w_win_id)*ADDR_WIDTH +: ADDR_WIDTH];
            ramDataIn  <= dataIn[32'(w_win_id)*WIDTH +: WIDTH];
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ACCESS: begin
          r_state <= S_DONE;
          ready   <= N_CORES'(1) << grantId;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// Bench for shared_ram_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level model of the arbitration rules and a shadow memory.
module tb_shared_ram_arbiter;
  localparam int N  = 4;
  localparam int W  = 12;
  localparam int D  = 256;
  localparam int AW = 8;
  localparam int IW = 2;

  logic            clk, rstN;
  logic [N-1:0]    req, wrEnIn, ready;
  logic [N*AW-1:0] addrIn;
  logic [N*W-1:0]  dataIn;
  logic [W-1:0]    rdData, ramDataIn, ramDataOut;
  logic            grantValid, ramWrEn;
  logic [IW-1:0]   grantId;
  logic [AW-1:0]   ramAddr;

  shared_ram_arbiter #(.N_CORES(N), .WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rstN(rstN), .req(req), .wrEnIn(wrEnIn), .addrIn(addrIn),
    .dataIn(dataIn), .ready(ready), .rdData(rdData), .grantValid(grantValid),
    .grantId(grantId), .ramWrEn(ramWrEn), .ramAddr(ramAddr),
    .ramDataIn(ramDataIn), .ramDataOut(ramDataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: synchronous write, registered read, plus a preload port
  logic [W-1:0]  mem [D] = '{default: '0};
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [W-1:0]  pre_data = '0;
  always @(posedge clk) begin
    if (pre_en)       mem[pre_addr] <= pre_data;
    else if (ramWrEn) mem[ramAddr]  <= ramDataIn;
    ramDataOut <= mem[ramAddr];
  end

  int n_total = 0;
  int n_bad   = 0;

  logic [W-1:0]  shadow [D] = '{default: '0};
  bit            t_wr   [N];
  logic [AW-1:0] t_addr [N];
  logic [W-1:0]  t_data [N];
  logic [N-1:0]  keep;
  bit            rand_mode;

  int  m_ptr, m_prev_g, m_prev_rdy, m_cap_addr;
  bit  m_prev_acc, m_cap_wr;
  logic [W-1:0] m_cap_data;
  int  waits [N];
  int  gq [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      wrEnIn[i]          = t_wr[i];
      addrIn[i*AW +: AW] = t_addr[i];
      dataIn[i*W +: W]   = t_data[i];
    end
  endtask

  task automatic raise(input int c, input bit wr, input logic [AW-1:0] a, input logic [W-1:0] d);
    t_wr[c] = wr; t_addr[c] = a; t_data[c] = d; req[c] = 1'b1;
    pack();
  endtask

  // Transaction-level reference: predicts grants, ready pulses, RAM port and read data
  task automatic monitor();
    logic [N-1:0] exp_rdy;
    bit pred_v;
    int pred_id;
    if (!rstN) begin
      m_ptr = 0; m_prev_acc = 0; m_prev_rdy = -1; m_prev_g = 0;
      for (int i = 0; i < N; i++) waits[i] = 0;
      return;
    end
    exp_rdy = m_prev_acc ? (N'(1) << m_prev_g) : '0;
    chk("ready", ready, exp_rdy);
    if (m_prev_acc && !m_cap_wr) chk("rddata", rdData, shadow[m_cap_addr]);
    if (m_prev_acc && m_cap_wr) shadow[m_cap_addr] = m_cap_data;
    pred_v = 0; pred_id = 0;
    if (!m_prev_acc) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (!pred_v && req[idx] && idx != m_prev_rdy) begin
          pred_v = 1; pred_id = idx;
        end
      end
    end
    chk("grant_valid", grantValid, pred_v);
    if (pred_v) begin
      chk("grant_id", grantId, pred_id);
      chk("ram_wren", ramWrEn, t_wr[pred_id]);
      chk("ram_addr", ramAddr, t_addr[pred_id]);
      if (t_wr[pred_id]) chk("ram_wdata", ramDataIn, t_data[pred_id]);
      for (int j = 0; j < N; j++) begin
        if (j != pred_id) waits[j] = req[j] ? waits[j] + 1 : 0;
      end
      chk("fairness", waits[pred_id] <= N - 1, 1);
      waits[pred_id] = 0;
      m_cap_wr = t_wr[pred_id]; m_cap_addr = int'(t_addr[pred_id]); m_cap_data = t_data[pred_id];
      m_ptr = (pred_id + 1) % N;
      gq.push_back(pred_id);
    end else begin
      chk("wren_idle", ramWrEn, 0);
    end
    m_prev_rdy = m_prev_acc ? m_prev_g : -1;
    m_prev_acc = pred_v;
    if (pred_v) m_prev_g = pred_id;
  endtask

  // One cycle: check at the falling edge, then act as the cores 1 time unit later
  task automatic step();
    @(negedge clk);
    monitor();
    #1;
    for (int i = 0; i < N; i++) begin
      if (req[i] && ready[i] && !keep[i]) req[i] = 1'b0;
      if (rand_mode && !req[i] && $urandom_range(0, 2) == 0) begin
        t_wr[i]   = 1'($urandom_range(0, 1));
        t_addr[i] = AW'($urandom_range(0, 15));
        t_data[i] = W'($urandom);
        req[i]    = 1'b1;
      end
    end
    pack();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_gvalid"}, grantValid, 0);
    chk({tag, "_gid"}, grantId, 0);
    chk({tag, "_wren"}, ramWrEn, 0);
    chk({tag, "_addr"}, ramAddr, 0);
    chk({tag, "_wdata"}, ramDataIn, 0);
  endtask

  task automatic pulse_reset();
    rstN = 1'b0;
    step(); step();
    rstN = 1'b1;
  endtask

  initial begin
    int cnt;
    logic [W-1:0] got;
    bit seen;
    rstN = 1'b0; req = '0; keep = '0; rand_mode = 0;
    for (int i = 0; i < N; i++) begin t_wr[i] = 0; t_addr[i] = '0; t_data[i] = '0; end
    pack();
    step(); step();
    chk_reset_outputs("por");
    rstN = 1'b1;
    step();

    // Preload and single read by core 2
    pre_en = 1'b1; pre_addr = 8'h10; pre_data = 12'hABC; shadow[8'h10] = 12'hABC;
    step();
    pre_en = 1'b0;
    raise(2, 0, 8'h10, '0);
    step();
    chk("single_gid", grantId, 2);
    step();
    chk("single_ready", ready, 4'b0100);
    chk("single_rd", rdData, 12'hABC);
    step(); step();

    // Write by core 0 followed by read of the same word by core 1
    pulse_reset();
    raise(0, 1, 8'h20, 12'h5A5);
    raise(1, 0, 8'h20, '0);
    cnt = 0; seen = 0; got = '0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (ramWrEn) cnt++;
      if (ready[1]) begin got = rdData; seen = 1; end
    end
    chk("wr_cycles", cnt, 1);
    chk("rd_seen", seen, 1);
    chk("rd_after_wr", got, 12'h5A5);

    // All four cores together: ready every other cycle in order 0..3
    pulse_reset();
    for (int i = 0; i < N; i++) raise(i, 0, AW'(i), '0);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("rr_ready", ready, (k % 2 == 0) ? (N'(1) << (k / 2 - 1)) : N'(0));
    end
    step();

    // Pointer wrapped after core 3: core 0 beats core 3
    raise(0, 0, 8'h01, '0);
    raise(3, 0, 8'h02, '0);
    step();
    chk("rotate_gid", grantId, 0);
    repeat (6) step();

    // Two continuous requesters must alternate
    gq.delete();
    keep = 4'b0110;
    raise(1, 0, 8'h03, '0);
    raise(2, 1, 8'h04, 12'h123);
    repeat (45) step();
    keep = '0;
    repeat (8) step();
    chk("starve_count", gq.size() >= 20, 1);
    for (int i = 1; i < gq.size(); i++) chk("starve_alt", gq[i] != gq[i-1], 1);

    // Reset during ACCESS aborts with no ready; pending requests re-arbitrated from core 0
    raise(3, 0, 8'h06, '0);
    raise(1, 0, 8'h05, '0);
    cnt = 0;
    while (!grantValid && cnt < 6) begin step(); cnt++; end
    chk("rst_reach_access", grantValid, 1);
    rstN = 1'b0;
    #1;
    chk_reset_outputs("mid");
    step();
    chk("mid_no_ready", ready, 0);
    step();
    chk("mid_no_ready2", ready, 0);
    rstN = 1'b1;
    step();
    chk("rearb_valid", grantValid, 1);
    chk("rearb_gid", grantId, 1);
    repeat (8) step();

    // Random traffic against the model
    rand_mode = 1;
    repeat (3000) step();
    rand_mode = 0;
    repeat (25) step();
    chk("drained", req, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/shared_ram_arbiter.md
# shared_ram_arbiter

Round-robin arbiter and sequencer that shares one single-port data RAM between `N_CORES` processor cores. Each core raises a request with address, write flag and write data. The arbiter grants one core at a time, drives the RAM port, and returns a one-cycle `ready` pulse with read data. It sits between the core array and the shared data memory: write takes effect in one RAM cycle, and read data appears the cycle after the address is presented.

## Interface
- `N_CORES`, 4, number of requesting cores (≥2)
- `WIDTH`, 12, data word width
- `DEPTH`, 256, RAM words
- `ADDR_WIDTH`, $clog2(DEPTH), address width
- `ID_WIDTH`, $clog2(N_CORES), grant index width

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rstN`  in  1  asynchronous, active-low reset
- `req`  in  N_CORES  per-core request; held high until `ready` seen
- `wrEnIn`  in  N_CORES  per-core write flag (1 = write, 0 = read)
- `addrIn`  in  N_CORES*ADDR_WIDTH  per-core address, core i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- `dataIn`  in  N_CORES*WIDTH  per-core write data, same packing
- `ready`  out  N_CORES  one-hot, one-cycle completion pulse
- `rdData`  out  WIDTH  read data, valid when `ready[g]`=1 for a read
- `grantValid`  out  1  a transaction is in ACCESS
- `grantId`  out  ID_WIDTH  core owning the ACCESS cycle
- `ramWrEn`  out  1  to RAM write enable
- `ramAddr`  out  ADDR_WIDTH  to RAM address
- `ramDataIn`  out  WIDTH  to RAM write data
- `ramDataOut`  in  WIDTH  from RAM read data

## Operation
- FSM states: IDLE, ACCESS, DONE.
- Arbitration: search `req` from pointer `ptr` upward, wrapping modulo N_CORES. The first set bit is the winner `g`. On grant, register `g`, `addrIn[g]`, `dataIn[g]`, `wrEnIn[g]`, and set `ptr <= (g+1) mod N_CORES`.
- IDLE: if any `req` is set, grant and go to ACCESS; else stay.
- ACCESS: `ramAddr`/`ramDataIn` come from captured registers. `ramWrEn` = captured write flag (only in ACCESS). `grantValid`=1, `grantId`=g. Always go to DONE.
- DONE: `ready[g]`=1. `rdData` = `ramDataOut` (combinational pass-through). In the same cycle, arbitrate over `req` with bit g masked. If a winner exists, grant it and go to ACCESS (back-to-back). Else go to IDLE.
- Outside ACCESS, `ramWrEn`=0 and `ramAddr`/`ramDataIn` hold their last captured values.
- Requester rule: keep `req`, `wrEnIn`, `addrIn`, `dataIn` stable from raising `req` until the cycle `ready` is high. Drop `req` the following cycle or issue a new request. Inputs are sampled only at grant.
- `req` dropped before `ready` (protocol violation): the transaction still completes and `ready` still pulses.
- `rdData` during a write completion is don't-care.

## Timing
- Reset (async, `rstN`=0): state IDLE, `ptr`=0, `ready`=0, `grantValid`=0, `grantId`=0, `ramWrEn`=0, `ramAddr`=0, `ramDataIn`=0. Reset mid-transaction aborts it with no `ready` pulse. A write aborted in ACCESS may or may not have landed.
- Latency, idle arbiter: `req` sampled high at edge T → ACCESS in cycle T+1 → `ready` and read data in cycle T+2.
- Sustained throughput: one transaction per 2 cycles with ≥2 requesters. A single requester that re-requests gets one per 3 cycles, because its own bit is masked in DONE.
- A write lands in RAM at the end of the ACCESS cycle. A read in the next transaction, even back-to-back, returns the new value.
- Fairness: a continuously requesting core waits at most N_CORES-1 transactions.

## Test plan
- Single read: after reset, preload RAM[0x10]=0xABC. Core 2 raises a read of 0x10 → `grantId`=2 one cycle later, `ready`=4'b0100 two cycles after `req`, `rdData`=0xABC.
- Write then read: core 0 writes 0x5A5 to 0x20, then core 1 reads 0x20 → `ramWrEn` high exactly one cycle. Core 1 then gets `rdData`=0x5A5.
- All four cores request simultaneously after reset → grants in order 0,1,2,3. `ready` pulses at cycles 2,4,6,8 relative to `req`, with no idle cycles between.
- Rotation: core 3 completes, then cores 0 and 3 request together → core 0 is granted first (ptr wrapped to 0).
- Starvation: cores 1 and 2 hold `req` continuously for 20 transactions → strictly alternating grants. Neither waits more than one transaction.
- Reset mid-operation: assert `rstN`=0 during ACCESS → all outputs return to reset values immediately with no `ready` pulse. After release, the pending `req` is re-arbitrated from core 0.
